// File: rtl/dw_window_generator.sv
// Streaming 3x3 sliding-window generator with implicit zero padding of 1,
// stride 1 or 2, feeding the depthwise 3x3 convolution engine.
module dw_window_generator #(
    parameter int MAX_WIDTH = 112
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      cfg_width,
    input  logic [7:0]      cfg_height,
    input  logic            cfg_stride2,
    input  logic [7:0]      in_pixel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [8:0][7:0] window_out,
    output logic            window_valid,
    output logic [7:0]      out_row,
    output logic [7:0]      out_col,
    output logic            busy,
    output logic            frame_done,
    output logic            cfg_error
);
    localparam int         AW       = $clog2(MAX_WIDTH + 1);
    localparam int         LB_DEPTH = 1 << AW;
    localparam logic [7:0] MAX_W8   = 8'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]      width_r, height_r;
    logic            stride2_r;
    logic [7:0]      y, x;
    logic [7:0]      lb0 [LB_DEPTH];
    logic [7:0]      lb1 [LB_DEPTH];
    logic [8:0][7:0] win_p0, win_nxt;
    logic [AW-1:0]   xi;
    logic            real_pos, step, last_step, emit, cfg_ok, accept;
    logic [7:0]      pixel, top, mid;

    always_comb begin
        xi        = x[AW-1:0];
        real_pos  = (y < height_r) && (x < width_r);
        step      = (state == RUN) && (!real_pos || in_valid);
        pixel     = real_pos ? in_pixel : 8'd0;
        // Rows above the frame read as zero; stale line-buffer content is masked here.
        top       = (y <= 8'd1) ? 8'd0 : lb0[xi];
        mid       = (y == 8'd0) ? 8'd0 : lb1[xi];
        last_step = (y == height_r) && (x == width_r);
        emit      = step && (y != 8'd0) && (x != 8'd0) && (!stride2_r || (y[0] && x[0]));
        cfg_ok    = (cfg_width != 8'd0) && (cfg_width <= MAX_W8) && (cfg_height != 8'd0);
        accept    = (state == IDLE) && start && cfg_ok;

        // Shift left one column; at x==0 the two left columns are left padding.
        win_nxt    = '0;
        win_nxt[0] = (x == 8'd0) ? 8'd0 : win_p0[1];
        win_nxt[1] = (x == 8'd0) ? 8'd0 : win_p0[2];
        win_nxt[3] = (x == 8'd0) ? 8'd0 : win_p0[4];
        win_nxt[4] = (x == 8'd0) ? 8'd0 : win_p0[5];
        win_nxt[6] = (x == 8'd0) ? 8'd0 : win_p0[7];
        win_nxt[7] = (x == 8'd0) ? 8'd0 : win_p0[8];
        win_nxt[2] = top;
        win_nxt[5] = mid;
        win_nxt[8] = pixel;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (step && last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready   = (state == RUN) && real_pos;
    assign busy       = (state == RUN);
    assign frame_done = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            x            <= 8'd0;
            y            <= 8'd0;
            width_r      <= 8'd0;
            height_r     <= 8'd0;
            stride2_r    <= 1'b0;
            window_valid <= 1'b0;
            window_out   <= '0;
            out_row      <= 8'd0;
            out_col      <= 8'd0;
            cfg_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            window_valid <= emit;
            cfg_error    <= (state == IDLE) && start && !cfg_ok;
            if (accept) begin
                width_r   <= cfg_width;
                height_r  <= cfg_height;
                stride2_r <= cfg_stride2;
                x         <= 8'd0;
                y         <= 8'd0;
            end else if (step) begin
                if (x == width_r) begin
                    x <= 8'd0;
                    y <= y + 8'd1;
                end else begin
                    x <= x + 8'd1;
                end
            end
            if (emit) begin
                window_out <= win_nxt;
                out_row    <= y - 8'd1;
                out_col    <= x - 8'd1;
            end
        end
    end

    // Stage p0: line buffers and working window advance on every step.
    always_ff @(posedge clock) begin
        if (step) begin
            lb0[xi] <= mid;
            lb1[xi] <= pixel;
            win_p0  <= win_nxt;
        end
    end

endmodule
